// File: rtl/loop_counter_n.sv
// loop_counter_n: N-digit decimal loop counter built from 10-position one-hot
// rings (software dekatrons) joined by a combinational ripple carry/borrow chain.
//
// Optional build macro: LOOP_COUNTER_SATURATE_EN -- when defined, wrapping
// steps hold at the limit (all-9 / all-0) instead of wrapping around. The
// flags are still set.
//
// Parameters:
//   DIGITS     number of decimal digits (1..8)
// Ports:
//   Clk        system clock, rising edge
//   Rst_n      asynchronous active-low reset
//   Step       count strobe, one count per cycle it is high
//   Reverse    0 = count up, 1 = count down (sampled with Step)
//   Load       synchronous parallel load of In
//   In         load value, packed BCD, digit 0 in [3:0]
//   Clear      synchronous clear of value and flags
//   Out        current value, packed BCD (combinational from ring state)
//   Zero       high when every digit is 0 (combinational)
//   Overflow   sticky, set on an up-step from all-9
//   Underflow  sticky, set on a down-step from all-0
module loop_counter_n #(
  parameter int unsigned DIGITS = 3
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Step,
  input  logic                  Reverse,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   In,
  input  logic                  Clear,
  output logic [4*DIGITS-1:0]   Out,
  output logic                  Zero,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int unsigned RING_W = 10;
  localparam int unsigned BCD_W  = 4;

  typedef logic [RING_W-1:0] ring_t;

  logic [DIGITS-1:0][RING_W-1:0] ring_q;
  logic [DIGITS-1:0][RING_W-1:0] ring_d;
  logic [DIGITS-1:0][RING_W-1:0] clean;
  logic                          at_limit;
  logic                          ovf_q, ovf_d;
  logic                          unf_q, unf_d;

  // A ring that is not one-hot restarts from position 0.
  function automatic ring_t legalize(input ring_t r);
    return $onehot(r) ? r : ring_t'(1);
  endfunction

  // Legalised view of the rings and detection of the all-9 / all-0 limit.
  always_comb begin
    at_limit = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      clean[k] = legalize(ring_q[k]);
      at_limit = at_limit & (Reverse ? clean[k][0] : clean[k][RING_W-1]);
    end
  end

  // Next-state: Clear > Load > Step > hold.
  always_comb begin
    logic         en;
    logic [3:0]   digit;
    ring_d = ring_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    en     = 1'b1;
    digit  = '0;
    if (Clear) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        ring_d[k] = ring_t'(1);
      end
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (Load) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        digit     = In[BCD_W*k +: BCD_W];
        ring_d[k] = (digit > 4'd9) ? ring_t'(1) : (ring_t'(1) << digit);
      end
    end else if (Step) begin
      // Ripple enable: a digit moves only when every lower digit is at its wrap point.
      for (int unsigned k = 0; k < DIGITS; k++) begin
        if (en) begin
          ring_d[k] = Reverse ? {clean[k][0], clean[k][RING_W-1:1]}
                              : {clean[k][RING_W-2:0], clean[k][RING_W-1]};
        end else begin
          ring_d[k] = clean[k];
        end
        en = en & (Reverse ? clean[k][0] : clean[k][RING_W-1]);
      end
      if (at_limit) begin
        if (Reverse) begin
          unf_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
`ifdef LOOP_COUNTER_SATURATE_EN
        ring_d = clean;
`endif
      end
    end
  end

  // State registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        ring_q[k] <= ring_t'(1);
      end
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ring_q <= ring_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // One-hot to BCD decode and zero detect.
  always_comb begin
    Out  = '0;
    Zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      for (int unsigned p = 0; p < RING_W; p++) begin
        if (ring_q[k][p]) begin
          Out[BCD_W*k +: BCD_W] = 4'(p);
        end
      end
      Zero = Zero & ring_q[k][0];
    end
  end

  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_loop_counter_n.sv
// Testbench for loop_counter_n (DIGITS=3): directed steps followed by random
// stimulus, checked against an integer-valued reference model.
module tb_loop_counter_n;

  localparam int unsigned D     = 3;
  localparam int unsigned OUT_W = 4*D;
  localparam int          MAXV  = 999;
`ifdef LOOP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             Clk;
  logic             Rst_n;
  logic             Step;
  logic             Reverse;
  logic             Load;
  logic [OUT_W-1:0] In;
  logic             Clear;
  logic [OUT_W-1:0] Out;
  logic             Zero;
  logic             Overflow;
  logic             Underflow;

  int  vectors     = 0;
  int  miscompares = 0;
  int  exp_val     = 0;
  bit  exp_ovf     = 1'b0;
  bit  exp_unf     = 1'b0;

  loop_counter_n #(.DIGITS(D)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Step      (Step),
    .Reverse   (Reverse),
    .Load      (Load),
    .In        (In),
    .Clear     (Clear),
    .Out       (Out),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [OUT_W-1:0] to_bcd(input int v);
    logic [OUT_W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < int'(D); k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int bcd_value(input logic [OUT_W-1:0] b);
    int v, m, d;
    v = 0;
    m = 1;
    for (int k = 0; k < int'(D); k++) begin
      d = int'(b[4*k +: 4]);
      if (d > 9) d = 0;
      v = v + d * m;
      m = m * 10;
    end
    return v;
  endfunction

  // Reference model: one clock edge worth of behaviour on an integer value.
  task automatic model_edge(input bit st, input bit rev, input bit ld,
                            input logic [OUT_W-1:0] din, input bit clr);
    if (clr) begin
      exp_val = 0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else if (ld) begin
      exp_val = bcd_value(din);
    end else if (st) begin
      if (!rev) begin
        if (exp_val == MAXV) begin
          exp_ovf = 1'b1;
          exp_val = SAT ? MAXV : 0;
        end else begin
          exp_val = exp_val + 1;
        end
      end else begin
        if (exp_val == 0) begin
          exp_unf = 1'b1;
          exp_val = SAT ? 0 : MAXV;
        end else begin
          exp_val = exp_val - 1;
        end
      end
    end
  endtask

  task automatic check(input string tag);
    logic [OUT_W-1:0] e_out;
    logic             e_zero;
    e_out  = to_bcd(exp_val);
    e_zero = (exp_val == 0);
    vectors++;
    assert (Out === e_out) else begin
      miscompares++;
      $error("FAIL %s Out got %h expected %h", tag, Out, e_out);
    end
    vectors++;
    assert (Zero === e_zero) else begin
      miscompares++;
      $error("FAIL %s Zero got %b expected %b", tag, Zero, e_zero);
    end
    vectors++;
    assert (Overflow === exp_ovf) else begin
      miscompares++;
      $error("FAIL %s Overflow got %b expected %b", tag, Overflow, exp_ovf);
    end
    vectors++;
    assert (Underflow === exp_unf) else begin
      miscompares++;
      $error("FAIL %s Underflow got %b expected %b", tag, Underflow, exp_unf);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, check #1 later.
  task automatic cyc(input string tag, input bit st, input bit rev, input bit ld,
                     input logic [OUT_W-1:0] din, input bit clr);
    Step    = st;
    Reverse = rev;
    Load    = ld;
    In      = din;
    Clear   = clr;
    @(posedge Clk);
    model_edge(st, rev, ld, din, clr);
    #1;
    check(tag);
  endtask

  initial begin
    logic [OUT_W-1:0] rin;
    int               r;
    Rst_n   = 1'b0;
    Step    = 1'b0;
    Reverse = 1'b0;
    Load    = 1'b0;
    In      = '0;
    Clear   = 1'b0;
    #12;
    check("reset");
    Rst_n = 1'b1;

    for (int i = 0; i < 5; i++) cyc("up5", 1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) cyc("down5", 1, 1, 0, '0, 0);

    cyc("load099", 0, 0, 1, 12'h099, 0);
    cyc("carry2", 1, 0, 0, '0, 0);

    cyc("load999", 0, 0, 1, 12'h999, 0);
    cyc("wrap_up", 1, 0, 0, '0, 0);
    cyc("wrap_dn", 1, 1, 0, '0, 0);
    cyc("clear", 0, 0, 0, '0, 1);

    cyc("load_step", 1, 0, 1, 12'h3A7, 0);
    cyc("clr_load", 0, 0, 1, 12'h555, 1);

    cyc("load999b", 0, 0, 1, 12'h999, 0);
    for (int i = 0; i < 3; i++) cyc("sat_up", 1, 0, 0, '0, 0);
    cyc("load000", 0, 0, 1, 12'h000, 0);
    cyc("sat_dn", 1, 1, 0, '0, 0);
    cyc("clear2", 0, 0, 0, '0, 1);

    // Asynchronous reset between edges while Step is held.
    cyc("pre_rst", 0, 0, 1, 12'h123, 0);
    Step    = 1'b1;
    Reverse = 1'b0;
    Load    = 1'b0;
    @(posedge Clk);
    model_edge(1, 0, 0, '0, 0);
    #2;
    Rst_n = 1'b0;
    #1;
    exp_val = 0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check("async_rst");
    @(negedge Clk);
    Rst_n = 1'b1;
    cyc("resume1", 1, 0, 0, '0, 0);
    cyc("resume2", 1, 0, 0, '0, 0);

    // Random stimulus, biased toward the wrap points.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 3))
        0:       rin = 12'h999;
        1:       rin = 12'h000;
        default: rin = OUT_W'($urandom);
      endcase
      cyc("rand", ($urandom_range(0, 3) != 0), 1'($urandom), (r < 10), rin, (r < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/loop_counter_n.md
# loop_counter_n

Parametrised N-digit decimal loop counter for the DekatronPC loop/bracket logic, generalising the fixed two-digit loop counter. Each digit is a 10-position one-hot ring, a software model of a dekatron, with a ripple carry/borrow chain between digits. The block steps up or down on a qualified strobe and supports synchronous parallel load and clear. It reports BCD value, zero, and separate sticky overflow and underflow flags.

## Interface
- DIGITS, 3, number of decimal digits (1..8); value range 0..10^DIGITS-1
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- Step  in  1  single-cycle count strobe, sampled at rising Clk
- Reverse  in  1  0 = count up, 1 = count down; sampled with Step
- Load  in  1  synchronous parallel load strobe
- In  in  4*DIGITS  load value, packed 8-4-2-1 BCD, digit 0 in [3:0]
- Clear  in  1  synchronous clear of value and flags
- Out  out  4*DIGITS  current value, packed 8-4-2-1 BCD, digit 0 in [3:0]
- Zero  out  1  high when every digit is 0
- Overflow  out  1  sticky; set on up-count wrap from all-9
- Underflow  out  1  sticky; set on down-count wrap from all-0

## Operation
- State: DIGITS one-hot 10-bit rings. Exactly one bit is hot per ring at all times.
- Reset: every ring is at position 0, Out=0, Zero=1, Overflow=0, Underflow=0.
- Per-edge priority: Clear > Load > Step > hold.
- Clear:
  - All rings go to 0; Overflow and Underflow go to 0.
  - Step and Load in the same cycle are ignored.
- Load:
  - Each BCD digit of In is converted to one-hot.
  - Any digit code >9 loads as 0.
  - Flags are unaffected.
  - A simultaneous Step is ignored.
- Step, per-digit enable chain:
  - En[0]=1.
  - En[k]=En[k-1] & (Reverse ? ring[k-1]==0 : ring[k-1]==9).
  - Each enabled ring rotates by one position: 9→0 up, 0→9 down.
- Wrap up: all digits at 9, Step with Reverse=0 → all digits 0, Overflow←1.
- Wrap down: all digits at 0, Step with Reverse=1 → all digits 9, Underflow←1.
- Flags stay set until Clear or Rst_n. A later opposite wrap does not clear the other flag; both may be high at once.
- Out: combinational one-hot→BCD of the ring state. Zero is combinational AND of every ring bit 0.
- Illegal ring state (not one-hot, only possible via upset): the next Step, Load or Clear forces that ring to a legal value. Step restarts it from 0 before rotation.

## Timing
- All state changes occur on rising Clk. Outputs reflect the new state after clock-to-out; no extra pipeline stage.
- Step-to-Out latency: 1 edge. Back-to-back Step on consecutive cycles is legal; each counts once.
- Step held high for n cycles counts n times; there is no edge detection.
- The carry chain is combinational within one cycle. DIGITS=8 must close timing at the project clock.
- Rst_n assertion takes effect immediately, independent of Clk, and aborts any in-flight Load or Step.
- Rst_n deassertion must be synchronous to Clk externally. The first edge after release may carry Step.

## Configuration
- LOOP_COUNTER_SATURATE_EN defined:
  - Up-Step from all-9 holds at all-9 and still sets Overflow.
  - Down-Step from all-0 holds at all-0 and still sets Underflow.
  - Lets loop depth counting stop at limits instead of aliasing.
- Not defined: modular wrap as described in Operation, which is the default.

## Test plan
- Reset, then 5 Steps with Reverse=0 (DIGITS=3) → Out=0x005, Zero=0, flags 0. Then 5 Steps with Reverse=1 → Out=0x000, Zero=1.
- Load In=0x099, one up-Step → Out=0x100, carry ripples two digits, Overflow=0.
- Load In=0x999, one up-Step → Out=0x000, Overflow=1. Then down-Step → Out=0x999, Underflow=1, Overflow still 1. Then Clear → Out=0, both flags 0.
- Same cycle Load=1, Step=1, In=0x3A7 → Out=0x307 (digit A loads as 0), no count applied. Same cycle Clear=1, Load=1 → Out=0.
- With LOOP_COUNTER_SATURATE_EN: at 0x999, 3 up-Steps → Out=0x999, Overflow=1. At 0x000, down-Step → Out=0x000, Underflow=1.
- Rst_n pulsed low mid-cycle between edges with Step=1 → Out=0 and flags 0 immediately. After release, counting resumes from 0.
